// File: rtl/ci_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ci_mon_pkg
// Purpose  : Shared types and constants for the CI commit monitor: FSM state
//            encoding, exit result codes, the riscv-tests gp PASS value and
//            a channel-index width helper.
// Revision : 1.0 - initial release
// ============================================================================
package ci_mon_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_PASS = 3'd2,
        S_FAIL = 3'd3,
        S_TMO  = 3'd4,
        S_HANG = 3'd5
    } state_t;

    // Why a RUN cycle ended (RES_NONE: it did not)
    localparam logic [2:0] RES_NONE = 3'd0;
    localparam logic [2:0] RES_PASS = 3'd1;
    localparam logic [2:0] RES_FAIL = 3'd2;
    localparam logic [2:0] RES_TMO  = 3'd3;
    localparam logic [2:0] RES_HANG = 3'd4;

    // riscv-tests convention: gp == 1 at ecall means every test passed
    localparam int GP_PASS = 1;

    // Width of a channel index; a single channel still needs one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : ci_mon_pkg
`default_nettype wire

// File: rtl/ci_commit_if.sv
`default_nettype none
// ============================================================================
// Module   : ci_commit_if
// Purpose  : Commit-stage bus seen by the monitor: per-channel valid, ecall
//            flag and architectural gp (x3) value. Channel 0 is oldest.
// Revision : 1.0 - initial release
// ============================================================================
interface ci_commit_if #(
    parameter int CW   = 2,
    parameter int XLEN = 64
);
    logic [CW-1:0]      commit_valid;
    logic [CW-1:0]      commit_ecall;
    logic [CW*XLEN-1:0] commit_gp;

    modport master (
        output commit_valid,
        output commit_ecall,
        output commit_gp
    );

    modport slave (
        input  commit_valid,
        input  commit_ecall,
        input  commit_gp
    );
endinterface : ci_commit_if
`default_nettype wire

// File: rtl/ci_first_sel.sv
`default_nettype none
// ============================================================================
// Module   : ci_first_sel
// Purpose  : Combinational find-first-set over i_req (bit 0 = highest
//            priority). Returns one-hot, index and found flag, plus the
//            popcount of i_cnt over bits 0..selected inclusive (all bits when
//            nothing is selected).
// Revision : 1.0 - initial release
// ============================================================================
module ci_first_sel
    import ci_mon_pkg::*;
#(
    parameter int CW = 2,
    parameter int IW = idx_w(CW),
    parameter int PW = $clog2(CW + 1)
) (
    input  wire logic [CW-1:0] i_req,
    input  wire logic [CW-1:0] i_cnt,
    output logic      [CW-1:0] o_onehot,
    output logic      [IW-1:0] o_idx,
    output logic               o_found,
    output logic      [PW-1:0] o_popcnt
);

    logic [CW-1:0] w_onehot;
    logic [IW-1:0] w_idx;
    logic          w_found;
    logic [PW-1:0] w_popcnt;

    // Scan oldest to youngest; count each channel until one past the first hit
    always_comb begin
        w_onehot = '0;
        w_idx    = '0;
        w_found  = 1'b0;
        w_popcnt = '0;
        for (int i = 0; i < CW; i++) begin
            if (!w_found) begin
                if (i_cnt[i]) begin
                    w_popcnt = w_popcnt + PW'(1);
                end
                if (i_req[i]) begin
                    w_found     = 1'b1;
                    w_onehot[i] = 1'b1;
                    w_idx       = IW'(i);
                end
            end
        end
    end

    assign o_onehot = w_onehot;
    assign o_idx    = w_idx;
    assign o_found  = w_found;
    assign o_popcnt = w_popcnt;

endmodule : ci_first_sel
`default_nettype wire

// File: rtl/ci_commit_monitor.sv
`default_nettype none
// ============================================================================
// Module   : ci_commit_monitor
// Purpose  : Pass/fail/timeout/hang monitor for CI regression runs. Decodes
//            the gp convention at the first committed ecall, enforces a run
//            timeout and a no-commit watchdog, and counts cycles/instret.
// Revision : 1.0 - initial release
// ============================================================================
module ci_commit_monitor
    import ci_mon_pkg::*;
#(
    parameter int CW         = 2,
    parameter int XLEN       = 64,
    parameter int TIMEOUT    = 16000,
    parameter int HANG_LIMIT = 1024
) (
    input  wire logic            CLK,
    input  wire logic            RSTn,
    input  wire logic            enable,
    ci_commit_if.slave           commit,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic                 timeout,
    output logic                 hang,
    output logic [XLEN-2:0]      fail_testnum,
    output logic [63:0]          cycle_cnt,
    output logic [63:0]          instret_cnt
);

    localparam int               IW        = idx_w(CW);
    localparam int               PW        = $clog2(CW + 1);
    localparam int               IDLE_W    = $clog2(HANG_LIMIT);
    localparam logic [63:0]      TMO_LAST  = 64'(TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] HANG_LAST = IDLE_W'(HANG_LIMIT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [63:0]         r_cycle_cnt,   w_cycle_nxt;
    logic [63:0]         r_instret_cnt, w_instret_nxt;
    logic [IDLE_W-1:0]   r_idle_cnt,    w_idle_nxt;
    logic [XLEN-2:0]     r_fail_tn,     w_tn_nxt;
    logic                r_done, r_pass, r_fail, r_tmo, r_hang;
    logic [2:0]          w_exit;

    logic [CW-1:0]       w_onehot;
    logic [IW-1:0]       w_idx;
    logic                w_found;
    logic [PW-1:0]       w_popcnt;
    logic [CW-1:0]       w_gp_one;
    logic                w_ecall_pass;
    logic                w_any_valid;
    logic [XLEN-2:0]     w_fail_tn;

    ci_first_sel #(
        .CW (CW)
    ) u_first_sel (
        .i_req    (commit.commit_valid & commit.commit_ecall),
        .i_cnt    (commit.commit_valid),
        .o_onehot (w_onehot),
        .o_idx    (w_idx),
        .o_found  (w_found),
        .o_popcnt (w_popcnt)
    );

    // Per-channel "gp says pass" so the selected ecall's verdict is a one-hot AND-OR
    for (genvar g = 0; g < CW; g++) begin : g_gp_one
        assign w_gp_one[g] = (commit.commit_gp[g*XLEN +: XLEN] == XLEN'(GP_PASS));
    end

    assign w_ecall_pass = |(w_onehot & w_gp_one);
    assign w_any_valid  = |commit.commit_valid;
    // Test number lives in gp[XLEN-1:1] of the selected (oldest) ecall channel
    assign w_fail_tn    = commit.commit_gp[int'(w_idx)*XLEN + 1 +: XLEN-1];

    // Next-state, counter and result-capture logic; enable low overrides everything
    always_comb begin
        w_state_nxt   = r_state;
        w_cycle_nxt   = r_cycle_cnt;
        w_instret_nxt = r_instret_cnt;
        w_idle_nxt    = r_idle_cnt;
        w_tn_nxt      = r_fail_tn;
        w_exit        = RES_NONE;
        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_tn_nxt    = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt   = S_RUN;
                    w_cycle_nxt   = '0;
                    w_instret_nxt = '0;
                    w_idle_nxt    = '0;
                    w_tn_nxt      = '0;
                end
                S_RUN: begin
                    w_cycle_nxt   = r_cycle_cnt + 64'd1;
                    w_instret_nxt = r_instret_cnt + 64'(w_popcnt);
                    if (w_any_valid) begin
                        w_idle_nxt = '0;
                    end else if (r_idle_cnt != {IDLE_W{1'b1}}) begin
                        w_idle_nxt = r_idle_cnt + IDLE_W'(1);
                    end
                    if (w_found) begin
                        w_exit = w_ecall_pass ? RES_PASS : RES_FAIL;
                    end else if (r_cycle_cnt == TMO_LAST) begin
                        w_exit = RES_TMO;
                    end else if (!w_any_valid && (r_idle_cnt == HANG_LAST)) begin
                        w_exit = RES_HANG;
                    end
                    case (w_exit)
                        RES_PASS: w_state_nxt = S_PASS;
                        RES_FAIL: begin
                            w_state_nxt = S_FAIL;
                            w_tn_nxt    = w_fail_tn;
                        end
                        RES_TMO:  w_state_nxt = S_TMO;
                        RES_HANG: w_state_nxt = S_HANG;
                        default:  w_state_nxt = S_RUN;
                    endcase
                end
                default: begin
                    // Terminal states: everything frozen until enable drops
                end
            endcase
        end
    end

    // State, counters and registered result flags
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state       <= S_IDLE;
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
            r_idle_cnt    <= '0;
            r_fail_tn     <= '0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_tmo         <= 1'b0;
            r_hang        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cycle_cnt   <= w_cycle_nxt;
            r_instret_cnt <= w_instret_nxt;
            r_idle_cnt    <= w_idle_nxt;
            r_fail_tn     <= w_tn_nxt;
            r_pass        <= (w_state_nxt == S_PASS);
            r_fail        <= (w_state_nxt == S_FAIL);
            r_tmo         <= (w_state_nxt == S_TMO);
            r_hang        <= (w_state_nxt == S_HANG);
            r_done        <= (w_state_nxt == S_PASS) || (w_state_nxt == S_FAIL) ||
                             (w_state_nxt == S_TMO)  || (w_state_nxt == S_HANG);
        end
    end

    assign done         = r_done;
    assign pass         = r_pass;
    assign fail         = r_fail;
    assign timeout      = r_tmo;
    assign hang         = r_hang;
    assign fail_testnum = r_fail_tn;
    assign cycle_cnt    = r_cycle_cnt;
    assign instret_cnt  = r_instret_cnt;

endmodule : ci_commit_monitor
`default_nettype wire

// File: tb/tb_ci_commit_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_ci_commit_monitor
// Purpose  : Scoreboard bench for ci_commit_monitor with a run-level
//            reference model, directed corner runs and randomized runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ci_commit_monitor;

    localparam int CW   = 2;
    localparam int XLEN = 64;
    localparam int TMO  = 100;
    localparam int HL   = 16;
    localparam int BOUND = TMO + HL + 20;

    logic            CLK    = 1'b0;
    logic            RSTn   = 1'b0;
    logic            enable = 1'b0;
    logic            done, pass, fail, timeout, hang;
    logic [XLEN-2:0] fail_testnum;
    logic [63:0]     cycle_cnt, instret_cnt;

    ci_commit_if #(.CW(CW), .XLEN(XLEN)) cif ();

    ci_commit_monitor #(
        .CW(CW), .XLEN(XLEN), .TIMEOUT(TMO), .HANG_LIMIT(HL)
    ) dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .enable       (enable),
        .commit       (cif),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .timeout      (timeout),
        .hang         (hang),
        .fail_testnum (fail_testnum),
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  e;
        logic [63:0] gp0;
        logic [63:0] gp1;
    } beat_t;

    typedef struct {
        bit          pass;
        bit          fail;
        bit          tmo;
        bit          hang;
        logic [62:0] tn;
        logic [63:0] cyc;
        logic [63:0] inst;
    } exp_t;

    beat_t stim[$];
    exp_t  sb_q[$];
    exp_t  last_exp;
    int    n_tests = 0;
    int    n_fail  = 0;
    logic  prev_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input logic [1:0] v, input logic [1:0] e,
                                 input logic [63:0] gp0, input logic [63:0] gp1);
        beat_t b;
        b.v = v; b.e = e; b.gp0 = gp0; b.gp1 = gp1;
        return b;
    endfunction

    function automatic beat_t beat_at(input int k);
        if (k < stim.size()) return stim[k];
        return mk(2'b00, 2'b00, 64'd0, 64'd0);
    endfunction

    // Whole-run reference: walk the stimulus cycle by cycle and apply the
    // retirement, timeout and watchdog rules directly.
    function automatic exp_t model();
        exp_t r;
        int   idle_run;
        r.pass = 0; r.fail = 0; r.tmo = 0; r.hang = 0;
        r.tn = '0; r.cyc = '0; r.inst = '0;
        idle_run = 0;
        for (int k = 0; k < BOUND; k++) begin
            beat_t       b;
            int          first;
            int          last;
            logic [63:0] gp;
            b = beat_at(k);
            first = -1;
            for (int c = 0; c < CW; c++)
                if (first < 0 && b.v[c] && b.e[c]) first = c;
            last = (first >= 0) ? first : CW - 1;
            for (int c = 0; c <= last; c++) r.inst += 64'(b.v[c]);
            r.cyc += 1;
            if (first >= 0) begin
                gp = (first == 0) ? b.gp0 : b.gp1;
                if (gp == 64'd1) r.pass = 1;
                else begin
                    r.fail = 1;
                    r.tn   = gp[63:1];
                end
                return r;
            end
            if (r.cyc == 64'(TMO)) begin
                r.tmo = 1;
                return r;
            end
            if (b.v != 2'b00) idle_run = 0;
            else idle_run++;
            if (idle_run == HL) begin
                r.hang = 1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic drive_beat(input beat_t b);
        cif.commit_valid = b.v;
        cif.commit_ecall = b.e;
        cif.commit_gp    = {b.gp1, b.gp0};
    endtask

    task automatic drive_zero();
        drive_beat(mk(2'b00, 2'b00, 64'd0, 64'd0));
    endtask

    // Scoreboard monitor: a fresh done pops one expected run result
    always @(negedge CLK) begin
        exp_t x;
        if (done && !prev_done) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: actual=1 required=0 (t=%0t)", $time);
            end else begin
                x = sb_q.pop_front();
                chk("pass_flag",    64'(pass),         64'(x.pass));
                chk("fail_flag",    64'(fail),         64'(x.fail));
                chk("timeout_flag", 64'(timeout),      64'(x.tmo));
                chk("hang_flag",    64'(hang),         64'(x.hang));
                chk("fail_testnum", 64'(fail_testnum), 64'(x.tn));
                chk("cycle_cnt",    cycle_cnt,         x.cyc);
                chk("instret_cnt",  instret_cnt,       x.inst);
            end
        end
        prev_done = done;
    end

    // One armed run over the current stim queue, then disarm and check clearing
    task automatic run_scenario();
        int k;
        last_exp = model();
        sb_q.push_back(last_exp);
        @(negedge CLK);
        drive_zero();
        enable = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("rearm_cycle_zero",   cycle_cnt,   64'd0);
        chk("rearm_instret_zero", instret_cnt, 64'd0);
        drive_beat(beat_at(0));
        k = 1;
        forever begin
            @(negedge CLK);
            if (done) break;
            if (k >= BOUND) begin
                chk("run_bound_done", 64'(done), 64'd1);
                break;
            end
            drive_beat(beat_at(k));
            k++;
        end
        drive_zero();
        repeat (3) @(negedge CLK);
        chk("frozen_cycle",   cycle_cnt,   last_exp.cyc);
        chk("frozen_instret", instret_cnt, last_exp.inst);
        enable = 1'b0;
        @(negedge CLK);
        chk("disarm_flags", 64'({done, pass, fail, timeout, hang}), 64'd0);
        chk("disarm_tn",    64'(fail_testnum), 64'd0);
        chk("disarm_cycle_hold",   cycle_cnt,   last_exp.cyc);
        chk("disarm_instret_hold", instret_cnt, last_exp.inst);
    endtask

    function automatic logic [63:0] pick_gp();
        case ($urandom_range(0, 3))
            0, 1:    return 64'd1;
            2:       return 64'($urandom_range(0, 15));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        drive_zero();
        // Reset state
        @(negedge CLK);
        chk("reset_flags",   64'({done, pass, fail, timeout, hang}), 64'd0);
        chk("reset_tn",      64'(fail_testnum), 64'd0);
        chk("reset_cycle",   cycle_cnt,   64'd0);
        chk("reset_instret", instret_cnt, 64'd0);
        RSTn = 1'b1;

        // Commits while disarmed must be ignored
        drive_beat(mk(2'b11, 2'b11, 64'd1, 64'd1));
        repeat (3) @(negedge CLK);
        chk("idle_ignore_done",    64'(done), 64'd0);
        chk("idle_ignore_instret", instret_cnt, 64'd0);
        drive_zero();

        // 50 single commits then ecall gp=1 on ch0
        stim.delete();
        for (int i = 0; i < 50; i++) stim.push_back(mk(2'b01, 2'b00, 64'd1, 64'd0));
        stim.push_back(mk(2'b01, 2'b01, 64'd1, 64'd0));
        run_scenario();

        // Two ecalls same cycle: ch0 gp=7 wins, ch1 ignored
        stim.delete();
        stim.push_back(mk(2'b11, 2'b00, 64'd0, 64'd0));
        stim.push_back(mk(2'b11, 2'b11, 64'd7, 64'd1));
        run_scenario();

        // Plain ch0 plus ecall on ch1 retires two
        stim.delete();
        for (int i = 0; i < 5; i++) stim.push_back(mk(2'b11, 2'b00, 64'd0, 64'd0));
        stim.push_back(mk(2'b11, 2'b10, 64'd0, 64'd1));
        run_scenario();

        // gp == 0 is a fail with test number 0
        stim.delete();
        stim.push_back(mk(2'b01, 2'b01, 64'd0, 64'd1));
        run_scenario();

        // Timeout with steady commits
        stim.delete();
        for (int i = 0; i < 120; i++) stim.push_back(mk(2'b01, 2'b00, 64'd0, 64'd0));
        run_scenario();

        // Ecall on the timeout cycle wins
        stim.delete();
        for (int i = 0; i < 99; i++) stim.push_back(mk(2'b01, 2'b00, 64'd0, 64'd0));
        stim.push_back(mk(2'b01, 2'b01, 64'd1, 64'd0));
        run_scenario();

        // Commits stop after 10 cycles -> hang
        stim.delete();
        for (int i = 0; i < 10; i++) stim.push_back(mk(2'b01, 2'b00, 64'd0, 64'd0));
        run_scenario();

        // Abort by dropping enable mid-run: no flags, counters hold
        @(negedge CLK);
        enable = 1'b1;
        @(posedge CLK);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            drive_beat(mk(2'b01, 2'b00, 64'd0, 64'd0));
        end
        @(negedge CLK);
        drive_zero();
        enable = 1'b0;
        @(negedge CLK);
        chk("abort_flags",   64'({done, pass, fail, timeout, hang}), 64'd0);
        chk("abort_cycle",   cycle_cnt,   64'd5);
        chk("abort_instret", instret_cnt, 64'd5);

        // Asynchronous reset mid-run
        @(negedge CLK);
        enable = 1'b1;
        @(posedge CLK);
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            drive_beat(mk(2'b11, 2'b00, 64'd0, 64'd0));
        end
        @(negedge CLK);
        drive_zero();
        chk("prereset_cycle",   cycle_cnt,   64'd7);
        chk("prereset_instret", instret_cnt, 64'd14);
        #1 RSTn = 1'b0;
        #1;
        chk("async_rst_flags",   64'({done, pass, fail, timeout, hang}), 64'd0);
        chk("async_rst_tn",      64'(fail_testnum), 64'd0);
        chk("async_rst_cycle",   cycle_cnt,   64'd0);
        chk("async_rst_instret", instret_cnt, 64'd0);
        enable = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;

        // Randomized runs
        for (int r = 0; r < 30; r++) begin
            int len;
            bit sparse;
            beat_t b;
            stim.delete();
            len    = $urandom_range(1, 130);
            sparse = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < len; i++) begin
                if (sparse) b.v = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
                else        b.v = 2'($urandom);
                b.e   = ($urandom_range(0, 49) == 0) ? 2'($urandom) : 2'b00;
                b.gp0 = pick_gp();
                b.gp1 = pick_gp();
                stim.push_back(b);
            end
            run_scenario();
        end

        repeat (3) @(negedge CLK);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_watchdog: actual=expired required=finished");
        $fatal(1, "global watchdog expired");
    end

endmodule : tb_ci_commit_monitor
`default_nettype wire
